// File: rtl/lcd_pkg.sv
// lcd_pkg: shared states, control bit positions, init ROM and command constants for the LCD writer
package lcd_pkg;
  typedef enum logic [3:0] {
    PWRUP, IDLE, HI_SETUP, HI_PULSE, HI_HOLD, LO_SETUP, LO_PULSE, LO_HOLD, EXEC_WAIT
  } state_t;

  localparam int CTRL_E  = 0;
  localparam int CTRL_RW = 1;
  localparam int CTRL_RS = 2;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  typedef struct packed {
    logic [7:0] val;
    logic       nib;
    logic       long_w;
  } init_t;

  // Nibble-only entries carry their nibble in val[7:4]
  function automatic init_t init_rom(input logic [2:0] i);
    case (i)
      3'd0:    return '{8'h30, 1'b1, 1'b1};
      3'd1:    return '{8'h30, 1'b1, 1'b0};
      3'd2:    return '{8'h30, 1'b1, 1'b0};
      3'd3:    return '{8'h20, 1'b1, 1'b0};
      3'd4:    return '{8'h28, 1'b0, 1'b0};
      3'd5:    return '{8'h0C, 1'b0, 1'b0};
      3'd6:    return '{8'h06, 1'b0, 1'b0};
      default: return '{CMD_CLEAR, 1'b0, 1'b0};
    endcase
  endfunction

  function automatic logic is_slow(input logic rs, input logic [7:0] d);
    return !rs && (d == CMD_CLEAR || d == CMD_HOME || d == 8'h03);
  endfunction

  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/lcd_delay_timer.sv
// lcd_delay_timer: loadable down-counter that parks at zero and flags it
module lcd_delay_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: HD44780 4-bit byte writer with E strobe timing and exec waits
// Define LCD_INIT_SEQ_EN to run the power-on 4-bit init sequence after reset.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = 2,
  parameter int E_HIGH_CYC     = 12,
  parameter int HOLD_CYC       = 2,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int POWERUP_CYC    = 750000,
  parameter int INIT_LONG_CYC  = 205000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [3:0] dataout,
  output logic [2:0] control,
  output logic       led
);
  localparam int W = $clog2(imax(imax(imax(SETUP_CYC, E_HIGH_CYC), imax(HOLD_CYC, CMD_WAIT_CYC)),
                                 imax(imax(CLEAR_WAIT_CYC, POWERUP_CYC), INIT_LONG_CYC)) + 1);
`ifdef LCD_INIT_SEQ_EN
  localparam state_t RST_ST = PWRUP;
`else
  localparam state_t RST_ST = IDLE;
`endif

  state_t         state, state_n;
  logic [7:0]     byte_q;
  logic           rs_q, nib_q, long_q, armed, more, ld, zero, accept;
  logic [W-1:0]   ld_val;
  logic [3:0]     d_n;
  logic [2:0]     c_n;
  logic           rdy_n, led_n;

  assign accept = state == IDLE && in_valid;

`ifdef LCD_INIT_SEQ_EN
  logic [2:0] idx;
  init_t      rom_n;
  assign rom_n = init_rom(state == PWRUP ? 3'd0 : idx + 3'd1);
  assign more  = armed && idx != 3'd7;
`else
  assign armed = 1'b0;
  assign more  = 1'b0;
`endif

  lcd_delay_timer #(.W(W)) u_tmr (
    .clk(clk),
    .rst(rst),
    .load(ld),
    .value(ld_val),
    .zero(zero)
  );

  // Outputs are registered from the current state, so they trail the state by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RST_ST;
      byte_q   <= '0;
      rs_q     <= 1'b0;
      nib_q    <= 1'b0;
      long_q   <= 1'b0;
      dataout  <= '0;
      control  <= '0;
      in_ready <= 1'b0;
      led      <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
      armed    <= 1'b0;
      idx      <= '0;
`endif
    end else begin
      state    <= state_n;
      dataout  <= d_n;
      control  <= c_n;
      in_ready <= rdy_n;
      led      <= led_n;
      if (accept) {byte_q, rs_q, nib_q, long_q} <= {in_data, in_rs, 2'b00};
`ifdef LCD_INIT_SEQ_EN
      if (state == PWRUP && !armed) armed <= 1'b1;
      if (armed && state_n == HI_SETUP && state != HI_SETUP) {byte_q, nib_q, long_q, rs_q} <= {rom_n, 1'b0};
      if (armed && state == EXEC_WAIT && zero) begin
        if (idx == 3'd7) armed <= 1'b0;
        else idx <= idx + 3'd1;
      end
`endif
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      PWRUP:     if (armed && zero) state_n = HI_SETUP;
      IDLE:      if (in_valid) state_n = HI_SETUP;
      HI_SETUP:  if (zero) state_n = HI_PULSE;
      HI_PULSE:  if (zero) state_n = HI_HOLD;
      HI_HOLD:   if (zero) state_n = nib_q ? EXEC_WAIT : LO_SETUP;
      LO_SETUP:  if (zero) state_n = LO_PULSE;
      LO_PULSE:  if (zero) state_n = LO_HOLD;
      LO_HOLD:   if (zero) state_n = EXEC_WAIT;
      EXEC_WAIT: if (zero) state_n = more ? HI_SETUP : IDLE;
      default:   state_n = IDLE;
    endcase
    ld = state_n != state || (state == PWRUP && !armed);
    case (state_n)
      PWRUP:              ld_val = W'(POWERUP_CYC - 1);
      HI_SETUP, LO_SETUP: ld_val = W'(SETUP_CYC - 1);
      HI_PULSE, LO_PULSE: ld_val = W'(E_HIGH_CYC - 1);
      HI_HOLD, LO_HOLD:   ld_val = W'(HOLD_CYC - 1);
      EXEC_WAIT:          ld_val = long_q ? W'(INIT_LONG_CYC - 1) :
                                   is_slow(rs_q, byte_q) ? W'(CLEAR_WAIT_CYC - 1) : W'(CMD_WAIT_CYC - 1);
      default:            ld_val = '0;
    endcase
  end

  always_comb begin
    d_n = state == HI_SETUP ? byte_q[7:4] : state == LO_SETUP ? byte_q[3:0] : dataout;
    c_n = '0;
    c_n[CTRL_RS] = (state == HI_SETUP || state == LO_SETUP) ? rs_q : control[CTRL_RS];
    c_n[CTRL_RW] = 1'b0;
    c_n[CTRL_E]  = state == HI_PULSE || state == LO_PULSE;
    rdy_n = state_n == IDLE;
    led_n = led | rdy_n;
  end
endmodule

// File: tb/tb_lcd_byte_writer.sv
// tb_lcd_byte_writer: directed vector bench for lcd_byte_writer (both LCD_INIT_SEQ_EN builds)
module tb_lcd_byte_writer;
  localparam int SETUP = 2, EH = 4, HOLD = 2, CMDW = 10, CLRW = 40, PWR = 50, ILONG = 20;

  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_rs = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, led;
  logic [3:0] dataout;
  logic [2:0] control;

  lcd_byte_writer #(
    .SETUP_CYC(SETUP), .E_HIGH_CYC(EH), .HOLD_CYC(HOLD), .CMD_WAIT_CYC(CMDW),
    .CLEAR_WAIT_CYC(CLRW), .POWERUP_CYC(PWR), .INIT_LONG_CYC(ILONG)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_rs(in_rs), .in_data(in_data),
    .in_ready(in_ready), .dataout(dataout), .control(control), .led(led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0, acc_cyc = 0;
  int rc[$], rn[$], rr[$], fc[$];
  int rdy_cyc = 0, rw_bad = 0, chg_bad = 0;
  bit mon_off = 1'b0;
  logic e_p = 1'b0, r_p = 1'b0, rs_p = 1'b0;
  logic [3:0] d_p = '0;

  always @(negedge clk) begin
    if (control[0] && !e_p) begin
      rc.push_back(cyc);
      rn.push_back(int'(dataout));
      rr.push_back(int'(control[2]));
    end
    if (!control[0] && e_p) fc.push_back(cyc);
    if (in_ready && !r_p) rdy_cyc <= cyc;
    if (control[1]) rw_bad <= rw_bad + 1;
    if (!mon_off && (control[0] || e_p) && (dataout != d_p || control[2] != rs_p)) chg_bad <= chg_bad + 1;
    e_p  <= control[0];
    r_p  <= in_ready;
    d_p  <= dataout;
    rs_p <= control[2];
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input int budget, input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk); #1;
      ok = in_ready;
    end
    chk({nm, "_ready"}, int'(ok), 1);
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    wait_ready(400, "send");
    in_valid = 1'b1;
    in_rs    = rs;
    in_data  = d;
    acc_cyc  = cyc + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rdy_drop", int'(in_ready), 0);
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         hi;
    int         lo;
    int         gap;
  } vec_t;

  vec_t vt[8];
  int   exp_init[12];

  initial begin
    bit ok;
    int b, b1, rel;
    vt[0] = '{1'b1, 8'h41, 4, 1, 11};
    vt[1] = '{1'b0, 8'h01, 0, 1, 41};
    vt[2] = '{1'b1, 8'h01, 0, 1, 11};
    vt[3] = '{1'b0, 8'h02, 0, 2, 41};
    vt[4] = '{1'b0, 8'h03, 0, 3, 41};
    vt[5] = '{1'b0, 8'h04, 0, 4, 11};
    vt[6] = '{1'b1, 8'h02, 0, 2, 11};
    vt[7] = '{1'b0, 8'h80, 8, 0, 11};
    exp_init = '{3, 3, 3, 2, 2, 8, 0, 12, 0, 6, 0, 1};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_dataout", int'(dataout), 0);
    chk("rst_control", int'(control), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_led", int'(led), 0);
    rst = 1'b0;
    rel = cyc;
    @(posedge clk); #1;
`ifdef LCD_INIT_SEQ_EN
    chk("post_rst_ready", int'(in_ready), 0);
    chk("post_rst_led", int'(led), 0);
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk); #1;
      ok = led;
    end
    chk("init_done", int'(ok), 1);
    chk("init_pulses", rc.size(), 12);
    if (rc.size() >= 12 && fc.size() >= 12) begin
      for (int i = 0; i < 12; i++) begin
        chk($sformatf("init%0d_nib", i), rn[i], exp_init[i]);
        chk($sformatf("init%0d_rs", i), rr[i], 0);
      end
      chk("pwrup_len", int'(rc[0] - rel >= PWR), 1);
      chk("long_wait", rc[1] - fc[0], 24);
      chk("clear_wait_led", rdy_cyc - fc[11], 41);
    end
    chk("init_ready", int'(in_ready), 1);
`else
    chk("post_rst_ready", int'(in_ready), 1);
    chk("post_rst_led", int'(led), 1);
`endif

    for (int i = 0; i < 8; i++) begin
      b = rc.size();
      send(vt[i].rs, vt[i].d);
      wait_ready(400, $sformatf("v%0d", i));
      chk($sformatf("v%0d_pulses", i), rc.size() - b, 2);
      if (rc.size() >= b + 2 && fc.size() >= b + 2) begin
        chk($sformatf("v%0d_hi", i), rn[b], vt[i].hi);
        chk($sformatf("v%0d_lo", i), rn[b+1], vt[i].lo);
        chk($sformatf("v%0d_rs_hi", i), rr[b], int'(vt[i].rs));
        chk($sformatf("v%0d_rs_lo", i), rr[b+1], int'(vt[i].rs));
        chk($sformatf("v%0d_ehigh_hi", i), fc[b] - rc[b], 4);
        chk($sformatf("v%0d_ehigh_lo", i), fc[b+1] - rc[b+1], 4);
        chk($sformatf("v%0d_latency", i), rc[b] - acc_cyc, 3);
        chk($sformatf("v%0d_done_gap", i), rdy_cyc - fc[b+1], vt[i].gap);
      end
    end

    b = rc.size();
    wait_ready(400, "stream0");
    in_valid = 1'b1;
    in_rs    = 1'b1;
    in_data  = 8'h48;
    @(posedge clk); #1;
    in_data = 8'h49;
    chk("stream_rdy_drop", int'(in_ready), 0);
    wait_ready(400, "stream1");
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_ready(400, "stream2");
    chk("stream_pulses", rc.size() - b, 4);
    if (rc.size() >= b + 4 && fc.size() >= b + 4) begin
      chk("stream_n0", rn[b], 4);
      chk("stream_n1", rn[b+1], 8);
      chk("stream_n2", rn[b+2], 4);
      chk("stream_n3", rn[b+3], 9);
      chk("stream_gap", int'(rc[b+2] - fc[b+1] >= CMDW), 1);
    end

    b = rc.size();
    send(1'b1, 8'h41);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk); #1;
      ok = control[0];
    end
    chk("reach_pulse", int'(ok), 1);
    mon_off = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_e", int'(control[0]), 0);
    chk("midrst_control", int'(control), 0);
    chk("midrst_dataout", int'(dataout), 0);
    chk("midrst_ready", int'(in_ready), 0);
    chk("midrst_led", int'(led), 0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    rel = cyc;
    @(posedge clk); #1;
    mon_off = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    chk("restart_ready", int'(in_ready), 0);
    chk("restart_led", int'(led), 0);
    b1 = rc.size();
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk); #1;
      ok = rc.size() > b1;
    end
    chk("restart_pulse", int'(ok), 1);
    if (rc.size() > b1) begin
      chk("restart_nib", rn[b1], 3);
      chk("restart_rs", rr[b1], 0);
      chk("restart_pwrup", int'(rc[b1] - rel >= PWR), 1);
    end
`else
    chk("restart_ready", int'(in_ready), 1);
    chk("restart_led", int'(led), 1);
    repeat (40) @(negedge clk);
    #1;
    chk("no_replay", rc.size() - b, 1);
`endif
    chk("rw_zero", rw_bad, 0);
    chk("stable_while_e", chg_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
